// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one 8-bit synchronous RAM port between
// instruction fetches (4 bytes) and data loads/stores (1/2/4 bytes); MEM wins over IF.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_data,
  output logic                  if_done,
  output logic                  if_rq,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic                  mem_rq,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [2:0]            cnt;
  logic [2:0]            len;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           wdata;
  logic [31:0]           asm_buf;
  logic [31:0]           assembled;
  logic [2:0]            cnt_inc;
  logic [ADDR_WIDTH-1:0] addr_inc;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      2'b00:   size_len = 3'd1;
      2'b01:   size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] w, input logic [1:0] idx,
                                              input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[idx*8 +: 8] = b;
    insert_byte = r;
  endfunction

  function automatic logic [7:0] select_byte(input logic [31:0] w, input logic [1:0] idx);
    select_byte = w[idx*8 +: 8];
  endfunction

  assign cnt_inc   = cnt + 3'd1;
  assign addr_inc  = base + ADDR_WIDTH'(cnt_inc);
  // Byte cnt-1 arrives on ram_din this cycle; fold it into the partial word.
  assign assembled = (cnt == 3'd0) ? asm_buf : insert_byte(asm_buf, 2'(cnt - 3'd1), ram_din);

  assign if_rq  = ~rst & if_req & ~if_done;
  assign mem_rq = ~rst & mem_req & ~mem_done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_req)     state_nxt = mem_we ? MEM_WR : MEM_RD;
        else if (if_req) state_nxt = IF_RD;
      end
      IF_RD: begin
        if (!if_req)         state_nxt = IDLE;
        else if (cnt == len) state_nxt = DONE;
      end
      MEM_RD: if (cnt == len) state_nxt = DONE;
      MEM_WR: if (cnt == len - 3'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      ram_addr  <= '0;
      ram_dout  <= 8'd0;
      ram_wr    <= 1'b0;
      if_data   <= 32'd0;
      if_done   <= 1'b0;
      mem_rdata <= 32'd0;
      mem_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      ram_wr   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (mem_req) begin
            ram_addr <= mem_addr;
            ram_dout <= mem_wdata[7:0];
            ram_wr   <= mem_we;
          end else if (if_req) begin
            ram_addr <= if_addr;
          end
        end
        IF_RD, MEM_RD: begin
          cnt <= cnt_inc;
          if (cnt_inc < len) ram_addr <= addr_inc;
          if (state_nxt == DONE) begin
            if (state == IF_RD) begin
              if_done <= 1'b1;
              if_data <= assembled;
            end else begin
              mem_done  <= 1'b1;
              mem_rdata <= assembled;
            end
          end
        end
        MEM_WR: begin
          cnt <= cnt_inc;
          if (state_nxt == DONE) begin
            mem_done <= 1'b1;
          end else begin
            ram_addr <= addr_inc;
            ram_dout <= select_byte(wdata, 2'(cnt_inc));
            ram_wr   <= 1'b1;
          end
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

  // Access descriptor and partial read word; meaningful only while an access is active.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        base    <= mem_req ? mem_addr : if_addr;
        len     <= mem_req ? size_len(mem_size) : 3'd4;
        wdata   <= mem_wdata;
        asm_buf <= 32'd0;
      end
      IF_RD, MEM_RD: asm_buf <= assembled;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: drivers push expected completions/RAM writes,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        if_rq;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_rq;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk_data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  exp_t exp_if[$];
  exp_t exp_mem[$];
  wr_t  exp_wr[$];
  wr_t  exp_addr[$];

  logic [7:0] ram [0:511];

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done), .if_rq(if_rq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_rq(mem_rq),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr[8:0]] <= ram_dout;
    ram_din <= ram[ram_addr[8:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  exp_t e;
  wr_t  w;

  always @(negedge clk) begin
    chk("if_rq", 32'(if_rq), 32'(~rst & if_req & ~if_done));
    chk("mem_rq", 32'(mem_rq), 32'(~rst & mem_req & ~mem_done));
    if (if_done) begin
      if (exp_if.size() == 0) chk("if_done_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_if.pop_front();
        chk("if_data", if_data, e.data);
        chk("if_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (mem_done) begin
      if (exp_mem.size() == 0) chk("mem_done_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_mem.pop_front();
        if (e.chk_data) chk("mem_rdata", mem_rdata, e.data);
        chk("mem_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (ram_wr) begin
      if (exp_wr.size() == 0) chk("ram_wr_unexpected", 32'd1, 32'd0);
      else begin
        w = exp_wr.pop_front();
        chk("ram_wr_addr", ram_addr, w.addr);
        chk("ram_wr_data", 32'(ram_dout), 32'(w.data));
        chk("ram_wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
    if (exp_addr.size() > 0 && exp_addr[0].cyc == cyc) begin
      w = exp_addr.pop_front();
      chk("ram_rd_addr", ram_addr, w.addr);
    end
  end

  task automatic do_if(input logic [31:0] addr, input logic [31:0] data, input int lat);
    int t;
    bit seen;
    @(posedge clk); #1;
    t = cyc;
    if_req  = 1'b1;
    if_addr = addr;
    exp_if.push_back('{data, t + lat, 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (if_done) seen = 1'b1;
    end
    if (!seen) chk("if_timeout", 32'd0, 32'd1);
    if_req = 1'b0;
  endtask

  task automatic do_mem(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] data, input int lat);
    int t;
    int n;
    bit seen;
    @(posedge clk); #1;
    t = cyc;
    mem_req   = 1'b1;
    mem_we    = we;
    mem_size  = size;
    mem_addr  = addr;
    mem_wdata = wdata;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (we)
      for (int i = 0; i < n; i++) exp_wr.push_back('{addr + 32'(i), wdata[8*i +: 8], t + 1 + i});
    exp_mem.push_back('{data, t + lat, !we});
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (mem_done) seen = 1'b1;
    end
    if (!seen) chk("mem_timeout", 32'd0, 32'd1);
    mem_req = 1'b0;
    mem_we  = 1'b0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    ram[9'h100] = 8'h13; ram[9'h101] = 8'h00; ram[9'h102] = 8'h00; ram[9'h103] = 8'h93;
    ram[9'h007] = 8'hF0;
    ram[9'h040] = 8'hCD; ram[9'h041] = 8'hAB;
    ram[9'h1FF] = 8'h34; ram[9'h000] = 8'h12;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = 2'b00; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    rst = 1'b0;

    // Fetch with read-address sequence.
    t = cyc + 1;
    for (int i = 0; i < 4; i++) exp_addr.push_back('{32'h100 + 32'(i), 8'h00, t + 1 + i});
    do_if(32'h100, 32'h93000013, 6);
    do_mem(1'b1, 2'b10, 32'h20, 32'hDEADBEEF, 32'h0, 5);
    do_mem(1'b0, 2'b00, 32'h7, 32'h0, 32'h000000F0, 3);

    // Simultaneous requests: MEM first, IF after done + one IDLE cycle.
    fork
      do_mem(1'b0, 2'b01, 32'h40, 32'h0, 32'h0000ABCD, 4);
      do_if(32'h100, 32'h93000013, 11);
    join

    // Fetch aborted at T+3, then a load.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) begin @(posedge clk); #1; end
    if_req = 1'b0;
    do_mem(1'b0, 2'b10, 32'h20, 32'h0, 32'hDEADBEEF, 6);

    do_mem(1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, 32'h00001234, 4);
    do_mem(1'b0, 2'b11, 32'h100, 32'h0, 32'h93000013, 6);
    do_mem(1'b1, 2'b01, 32'h50, 32'hAABBCCDD, 32'h0, 3);
    do_mem(1'b0, 2'b10, 32'h50, 32'h0, 32'h0000CCDD, 6);

    // Reset during the second byte of a word store.
    @(posedge clk); #1;
    t = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h30; mem_wdata = 32'h11223344;
    exp_wr.push_back('{32'h30, 8'h44, t + 1});
    exp_wr.push_back('{32'h31, 8'h33, t + 2});
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rst_mem_rq", 32'(mem_rq), 32'd0);
    chk("rst_if_rq", 32'(if_rq), 32'd0);
    @(posedge clk); #1;
    chk("rst2_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst2_ram_addr", ram_addr, 32'd0);
    chk("rst2_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst2_mem_rdata", mem_rdata, 32'd0);
    chk("rst2_if_data", if_data, 32'd0);
    chk("rst2_mem_done", 32'(mem_done), 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    do_if(32'h100, 32'h93000013, 6);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_if", 32'(exp_if.size()), 32'd0);
    chk("pending_mem", 32'(exp_mem.size()), 32'd0);
    chk("pending_wr", 32'(exp_wr.size()), 32'd0);
    chk("pending_addr", 32'(exp_addr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the IF/MEM pipeline stages and the single 8-bit synchronous RAM port.
- Issues the `if_rq` / `mem_rq` stall requests consumed by the pipeline controller, which converts them into `halt_type`.
- Serves one access at a time: a 4-byte instruction fetch, or a 1/2/4-byte data load/store.
- MEM has priority over IF.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high (`RstEnable` = 1'b1)
- if_req  in  1  IF requests a 4-byte fetch; held until if_done, or dropped to abort
- if_addr  in  ADDR_WIDTH  fetch address
- if_data  out  32  fetched instruction, little-endian
- if_done  out  1  one-cycle pulse; if_data valid this cycle
- if_rq  out  1  IF stall request = if_req & ~if_done (combinational; 0 during rst)
- mem_req  in  1  MEM requests an access; held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- mem_addr  in  ADDR_WIDTH  data address
- mem_wdata  in  32  store data, low bytes used
- mem_rdata  out  32  load data, zero-extended
- mem_done  out  1  one-cycle pulse; mem_rdata valid on loads
- mem_rq  out  1  MEM stall request = mem_req & ~mem_done (combinational; 0 during rst)
- ram_din  in  8  RAM read byte, valid the cycle after its address
- ram_dout  out  8  RAM write byte
- ram_addr  out  ADDR_WIDTH  RAM byte address
- ram_wr  out  1  1 = write ram_dout at ram_addr this cycle

Behaviour:
- Reset: state IDLE, byte counter 0, all registered outputs 0 (ram_addr, ram_dout, ram_wr, if_data, if_done, mem_rdata, mem_done).
  - Reset mid-access: access abandoned, ram_wr low in the next cycle, no done pulse.
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE:
  - Samples requests at the clock edge.
  - mem_req=1 -> MEM_RD or MEM_WR; otherwise if_req=1 -> IF_RD.
  - Latches base address, N (IF: 4; MEM: 1/2/4 from mem_size), wdata and we.
  - Counter cleared to 0.
- Reads (IF_RD, MEM_RD), counter c = 0..N:
  - While c<N: ram_addr = base+c, ram_wr=0.
  - While c>=1: byte c-1 = ram_din, placed at bits [8(c-1)+7 : 8(c-1)].
  - At c=N, capture the last byte and go to DONE.
- Writes (MEM_WR), c = 0..N-1:
  - ram_addr = base+c, ram_dout = wdata[8c+7:8c], ram_wr=1.
  - After c=N-1, go to DONE.
- DONE:
  - Exactly one cycle.
  - Pulses if_done or mem_done; data output holds the assembled word with unread upper bytes 0.
  - Then IDLE.
- Data outputs hold their value until the next completion of the same type.
- Latency, request sampled in IDLE cycle T:
  - Read done in cycle T+N+2 (word: T+6).
  - Write done in cycle T+N+1 (word: T+5).
  - Back-to-back accesses have one IDLE cycle between them.
- Stall requests:
  - if_rq / mem_rq stay high from req assertion until the cycle of the matching done.
  - A request waiting behind the other type keeps its rq high.
- Abort:
  - if_req low during IF_RD -> IDLE at next edge, no if_done, captured bytes discarded.
  - mem_req is never aborted; dropping it mid-access is a protocol violation and is ignored (access completes).
- Simultaneous if_req & mem_req in IDLE: MEM served first; IF served after mem_done plus one IDLE cycle.
- Address increment wraps modulo 2^ADDR_WIDTH.
- No alignment check; misaligned accesses proceed byte-by-byte.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,00,00,93 -> ram_addr 0x100..0x103 in cycles T+1..T+4; if_done in T+6 with if_data=0x93000013; if_rq falls in T+6.
- Store word: mem_we=1, mem_size=10, addr=0x20, wdata=0xDEADBEEF -> ram_wr=1 for 4 cycles writing EF,BE,AD,DE to 0x20..0x23; mem_done at T+5.
- Load byte: mem_size=00, addr=0x7, RAM[0x7]=0xF0 -> mem_rdata=0x000000F0, mem_done at T+3; exactly one ram_addr cycle.
- if_req and mem_req raised together (mem load half @0x40) -> MEM served first; if_rq held high throughout; IF starts one cycle after mem_done.
- Drop if_req at T+3 of a fetch -> no if_done, FSM IDLE at T+4; subsequent mem_req served normally.
- Assert rst during MEM_WR byte 1 -> ram_wr=0 next cycle; no mem_done; all outputs 0; if_rq=mem_rq=0 while rst high.
